// File: rtl/waveform_pkg.sv
// Shared types for the up/down wave generators and the triangle tracker.
package waveform_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEED = 2'd1,
    UP   = 2'd2,
    DOWN = 2'd3
  } tracker_state_t;

  // Slope direction encoding shared with the generator: 0 = rising, 1 = falling.
  typedef enum logic {
    DIR_RISE = 1'b0,
    DIR_FALL = 1'b1
  } wave_dir_t;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear and load-to-one.
module sat_counter #(
  parameter int unsigned W = 4
) (
  input  logic         clk,
  input  logic         clear,
  input  logic         load_one,
  input  logic         incr,
  output logic [W-1:0] count
);

  // Priority: clear, then restart at 1, then increment (held at all-ones).
  always_ff @(posedge clk) begin
    if (clear) begin
      count <= '0;
    end else if (load_one) begin
      count <= W'(1);
    end else if (incr && (count != '1)) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/triangle_tracker.sv
// Triangle-wave sample analyser: slope tracking, peak/trough events,
// trough-to-trough period measurement and step-size checking.
module triangle_tracker
  import waveform_pkg::*;
#(
  parameter int unsigned N        = 8,
  parameter int unsigned P        = N + 2,
  parameter int unsigned MAX_STEP = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         ena,
  input  logic [N-1:0] in,
  output logic         dir,
  output logic         peak,
  output logic         trough,
  output logic [N-1:0] extremum,
  output logic [P-1:0] period,
  output logic         period_valid,
  output logic         locked,
  output logic         step_err
);

  localparam int unsigned DW = N + 1;

  tracker_state_t      state;
  logic [N-1:0]        prev;
  logic                seen;
  logic [P-1:0]        count;

  logic signed [DW-1:0] delta;
  logic [DW-1:0]        mag;
  logic                 step_bad;
  logic                 rise;
  logic                 fall;
  logic                 trough_hit;

  // Non-wrapping signed delta between the new and previous sample.
  always_comb begin
    delta      = $signed({1'b0, in}) - $signed({1'b0, prev});
    mag        = delta[DW-1] ? DW'(-delta) : DW'(delta);
    step_bad   = (mag > DW'(MAX_STEP));
    rise       = !delta[DW-1] && (delta != '0);
    fall       = delta[DW-1];
    trough_hit = ena && (state == DOWN) && !step_bad && rise;
  end

  sat_counter #(
    .W (P)
  ) u_cnt (
    .clk      (clk),
    .clear    (rst),
    .load_one (trough_hit),
    .incr     (ena),
    .count    (count)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      prev         <= '0;
      seen         <= 1'b0;
      dir          <= 1'b0;
      peak         <= 1'b0;
      trough       <= 1'b0;
      extremum     <= '0;
      period       <= '0;
      period_valid <= 1'b0;
      locked       <= 1'b0;
      step_err     <= 1'b0;
    end else begin
      peak         <= 1'b0;
      trough       <= 1'b0;
      period_valid <= 1'b0;
      step_err     <= 1'b0;
      if (ena) begin
        prev <= in;
        unique case (state)
          IDLE: begin
            state <= SEED;
          end
          SEED: begin
            if (rise) begin
              state <= UP;
              dir   <= 1'(DIR_RISE);
            end else if (fall) begin
              state <= DOWN;
              dir   <= 1'(DIR_FALL);
            end
          end
          UP: begin
            if (step_bad) begin
              state    <= SEED;
              dir      <= 1'(DIR_RISE);
              step_err <= 1'b1;
              locked   <= 1'b0;
              seen     <= 1'b0;
            end else if (fall) begin
              state    <= DOWN;
              dir      <= 1'(DIR_FALL);
              peak     <= 1'b1;
              extremum <= prev;
            end
          end
          DOWN: begin
            if (step_bad) begin
              state    <= SEED;
              dir      <= 1'(DIR_RISE);
              step_err <= 1'b1;
              locked   <= 1'b0;
              seen     <= 1'b0;
            end else if (rise) begin
              state    <= UP;
              dir      <= 1'(DIR_RISE);
              trough   <= 1'b1;
              extremum <= prev;
              seen     <= 1'b1;
              // A period needs two troughs since reset or the last step error.
              if (seen) begin
                period       <= count;
                period_valid <= 1'b1;
                locked       <= 1'b1;
              end
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_triangle_tracker.sv
// Directed bench for triangle_tracker: vector table plus triangle, reset and saturation sequences.
module tb_triangle_tracker;
  import waveform_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic       ena;
  logic [7:0] in;
  logic       dir, peak, trough, period_valid, locked, step_err;
  logic [7:0] extremum;
  logic [9:0] period;

  logic       ena2;
  logic [1:0] in2;
  logic       dir2, peak2, trough2, period_valid2, locked2, step_err2;
  logic [1:0] extremum2;
  logic [3:0] period2;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  triangle_tracker #(.N(8), .P(10), .MAX_STEP(1)) dut (
    .clk(clk), .rst(rst), .ena(ena), .in(in), .dir(dir), .peak(peak), .trough(trough),
    .extremum(extremum), .period(period), .period_valid(period_valid),
    .locked(locked), .step_err(step_err)
  );

  triangle_tracker #(.N(2), .P(4), .MAX_STEP(1)) dut2 (
    .clk(clk), .rst(rst), .ena(ena2), .in(in2), .dir(dir2), .peak(peak2), .trough(trough2),
    .extremum(extremum2), .period(period2), .period_valid(period_valid2),
    .locked(locked2), .step_err(step_err2)
  );

  typedef struct {
    logic           e;
    logic [7:0]     v;
    logic           pk, tr, pv, se, lk, dr;
    logic [7:0]     ext;
    logic [9:0]     per;
    tracker_state_t st;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic e, input logic [7:0] v, input logic pk, input logic tr,
                              input logic [7:0] ext, input logic pv, input logic [9:0] per,
                              input logic lk, input logic se, input logic dr, input tracker_state_t st);
    vec_t r;
    r.e = e; r.v = v; r.pk = pk; r.tr = tr; r.ext = ext; r.pv = pv;
    r.per = per; r.lk = lk; r.se = se; r.dr = dr; r.st = st;
    return r;
  endfunction

  function automatic logic [23:0] outs();
    return {dir, peak, trough, period_valid, step_err, locked, extremum, period};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic apply(input logic e, input logic [7:0] v);
    ena = e; in = v;
    @(posedge clk); #1;
  endtask

  task automatic apply2(input logic [1:0] v);
    ena2 = 1'b1; in2 = v;
    @(posedge clk); #1;
    ena2 = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1; ena = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic run_triangle(input bit gap);
    int seq[$];
    logic [7:0] ext_e;
    logic [9:0] per_e;
    logic lk_e, pk, tr, pv, dr;
    int tc;
    seq.delete();
    for (int i = 0; i <= 255; i++) seq.push_back(i);
    for (int i = 254; i >= 0; i--) seq.push_back(i);
    for (int i = 1; i <= 255; i++) seq.push_back(i);
    for (int i = 254; i >= 0; i--) seq.push_back(i);
    seq.push_back(1);
    do_reset();
    ext_e = 8'd0; per_e = 10'd0; lk_e = 1'b0; tc = 0;
    for (int k = 0; k < seq.size(); k++) begin
      apply(1'b1, 8'(seq[k]));
      pk = (k > 0) && (seq[k-1] == 255);
      tr = (k >= 2) && (seq[k-1] == 0);
      if (pk) ext_e = 8'd255;
      if (tr) begin tc++; ext_e = 8'd0; end
      pv = tr && (tc >= 2);
      if (pv) begin per_e = 10'd510; lk_e = 1'b1; end
      dr = (k > 0) && (seq[k] < seq[k-1]);
      check(gap ? "gap_tri" : "tri", 32'(outs()), 32'({dr, pk, tr, pv, 1'b0, lk_e, ext_e, per_e}));
      if (gap) begin
        apply(1'b0, 8'($urandom_range(0, 255)));
        check("gap_hold", 32'(outs()), 32'({dr, 4'b0000, lk_e, ext_e, per_e}));
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; ena = 1'b0; in = 8'd0; ena2 = 1'b0; in2 = 2'd0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;

    // Reset and idle with ena low.
    for (int i = 0; i < 10; i++) begin
      apply(1'b0, 8'($urandom_range(0, 255)));
      check("idle_outs", 32'(outs()), 32'd0);
      check("idle_state", 32'(dut.state), 32'(IDLE));
    end

    // Plateau, turns, first period, step violation and recovery.
    vecs.push_back(mk(1, 3, 0,0, 0, 0,0, 0,0,0, SEED));
    vecs.push_back(mk(1, 4, 0,0, 0, 0,0, 0,0,0, UP));
    vecs.push_back(mk(1, 5, 0,0, 0, 0,0, 0,0,0, UP));
    vecs.push_back(mk(1, 5, 0,0, 0, 0,0, 0,0,0, UP));
    vecs.push_back(mk(0, 9, 0,0, 0, 0,0, 0,0,0, UP));
    vecs.push_back(mk(1, 5, 0,0, 0, 0,0, 0,0,0, UP));
    vecs.push_back(mk(1, 4, 1,0, 5, 0,0, 0,0,1, DOWN));
    vecs.push_back(mk(1, 3, 0,0, 5, 0,0, 0,0,1, DOWN));
    vecs.push_back(mk(1, 2, 0,0, 5, 0,0, 0,0,1, DOWN));
    vecs.push_back(mk(0, 200, 0,0, 5, 0,0, 0,0,1, DOWN));
    vecs.push_back(mk(1, 3, 0,1, 2, 0,0, 0,0,0, UP));
    vecs.push_back(mk(1, 4, 0,0, 2, 0,0, 0,0,0, UP));
    vecs.push_back(mk(1, 5, 0,0, 2, 0,0, 0,0,0, UP));
    vecs.push_back(mk(1, 4, 1,0, 5, 0,0, 0,0,1, DOWN));
    vecs.push_back(mk(1, 3, 0,0, 5, 0,0, 0,0,1, DOWN));
    vecs.push_back(mk(1, 2, 0,0, 5, 0,0, 0,0,1, DOWN));
    vecs.push_back(mk(1, 3, 0,1, 2, 1,6, 1,0,0, UP));
    for (int v = 4; v <= 11; v++) vecs.push_back(mk(1, 8'(v), 0,0, 2, 0,6, 1,0,0, UP));
    vecs.push_back(mk(1, 20, 0,0, 2, 0,6, 0,1,0, SEED));
    for (int v = 19; v >= 15; v--) vecs.push_back(mk(1, 8'(v), 0,0, 2, 0,6, 0,0,1, DOWN));
    vecs.push_back(mk(1, 16, 0,1, 15, 0,6, 0,0,0, UP));
    vecs.push_back(mk(1, 17, 0,0, 15, 0,6, 0,0,0, UP));
    vecs.push_back(mk(1, 18, 0,0, 15, 0,6, 0,0,0, UP));
    vecs.push_back(mk(1, 17, 1,0, 18, 0,6, 0,0,1, DOWN));
    vecs.push_back(mk(1, 16, 0,0, 18, 0,6, 0,0,1, DOWN));
    vecs.push_back(mk(1, 15, 0,0, 18, 0,6, 0,0,1, DOWN));
    vecs.push_back(mk(1, 16, 0,1, 15, 1,6, 1,0,0, UP));

    do_reset();
    for (int i = 0; i < vecs.size(); i++) begin
      apply(vecs[i].e, vecs[i].v);
      check($sformatf("vec%0d_outs", i), 32'(outs()),
            32'({vecs[i].dr, vecs[i].pk, vecs[i].tr, vecs[i].pv, vecs[i].se,
                 vecs[i].lk, vecs[i].ext, vecs[i].per}));
      check($sformatf("vec%0d_state", i), 32'(dut.state), 32'(vecs[i].st));
    end

    // Full triangle, continuous then gapped ena.
    run_triangle(1'b0);
    run_triangle(1'b1);

    // Reset while falling discards history; the next sample only seeds.
    apply(1'b1, 8'd0);
    check("pre_rst_dir", 32'(dir), 32'd1);
    check("pre_rst_state", 32'(dut.state), 32'(DOWN));
    rst = 1'b1; ena = 1'b1; in = 8'd5;
    @(posedge clk); #1;
    rst = 1'b0;
    check("rst_outs", 32'(outs()), 32'd0);
    check("rst_state", 32'(dut.state), 32'(IDLE));
    apply(1'b1, 8'd7);
    check("post_rst_seed_outs", 32'(outs()), 32'd0);
    check("post_rst_seed_state", 32'(dut.state), 32'(SEED));
    apply(1'b1, 8'd6);
    check("post_rst_down_outs", 32'(outs()), 32'h800000);
    ena = 1'b0;

    // Period counter saturation on a 2-bit stream with a long plateau.
    apply2(2'd1);
    apply2(2'd0);
    apply2(2'd1);
    check("sat_first_trough", 32'({trough2, period_valid2, extremum2}), 32'({1'b1, 1'b0, 2'd0}));
    apply2(2'd2);
    apply2(2'd3);
    for (int i = 0; i < 20; i++) apply2(2'd3);
    check("sat_count", 32'(dut2.u_cnt.count), 32'd15);
    check("sat_no_period_yet", 32'(period2), 32'd0);
    apply2(2'd2);
    check("sat_peak", 32'({peak2, extremum2}), 32'({1'b1, 2'd3}));
    apply2(2'd1);
    apply2(2'd0);
    check("sat_count_held", 32'(dut2.u_cnt.count), 32'd15);
    apply2(2'd1);
    check("sat_period", 32'({period_valid2, locked2, period2}), 32'({1'b1, 1'b1, 4'd15}));
    check("sat_restart", 32'(dut2.u_cnt.count), 32'd1);
    check("sat_no_step_err", 32'(step_err2), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
